// File: rtl/abro_pkg.sv
// abro_pkg: shared state encoding, mode codes and sizing helper for the ABRO stimulus driver
package abro_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_FIRST,
        S_GAP,
        S_SECOND,
        S_WAIT,
        S_DONE
    } abro_drv_state_t;
    localparam logic [1:0] MODE_AB  = 2'b00;
    localparam logic [1:0] MODE_BA  = 2'b01;
    localparam logic [1:0] MODE_SIM = 2'b10;
    localparam logic [1:0] MODE_BAD = 2'b11;
    function automatic int max_w(int a, int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/abro_cnt.sv
// abro_cnt: loadable up/down counter with a terminal-count compare
module abro_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_din,
    input  logic         i_en,
    input  logic         i_up,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_q,
    output logic         o_tc
);
    logic [W-1:0] r_q;
    always_ff @(posedge clk) begin
        if (!reset)
            r_q <= '0;
        else if (i_load)
            r_q <= i_din;
        else if (i_en)
            r_q <= i_up ? r_q + W'(1) : r_q - W'(1);
    end
    assign o_q  = r_q;
    assign o_tc = r_q == i_term;
endmodule

// File: rtl/abro_stim_driver.sv
// abro_stim_driver: ABRO initiator that resets the responder, drives A/B and times its O response
module abro_stim_driver
    import abro_pkg::*;
#(
    parameter int GAP_W   = 8,
    parameter int TIMEOUT = 16,
    parameter int RST_LEN = 2,
    parameter int LAT_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             level,
    input  logic [GAP_W-1:0] gap,
    input  logic             O,
    output logic             dut_reset_n,
    output logic             A,
    output logic             B,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             early,
    output logic [LAT_W-1:0] o_latency
);
    localparam int CW = max_w(GAP_W, LAT_W);
    abro_drv_state_t r_state, w_next;
    logic [1:0] r_mode;
    logic r_level;
    logic [GAP_W-1:0] r_gap;
    logic r_rstn, r_a, r_b, r_busy, r_done, r_pass, r_timeout, r_early;
    logic [LAT_W-1:0] r_lat;
    logic w_accept, w_o_early, w_load, w_en, w_up, w_tc;
    logic [CW-1:0] w_din, w_term, w_q;
    logic w_fa, w_sa, w_a, w_b, w_rstn, w_busy, w_done;
    assign w_accept  = start && mode != MODE_BAD;
    assign w_o_early = O && r_state inside {S_FIRST, S_GAP, S_SECOND};
    assign w_en      = r_state inside {S_RST, S_GAP, S_WAIT};
    assign w_up      = r_state == S_WAIT;
    assign w_term    = r_state == S_WAIT ? CW'(TIMEOUT - 1) : CW'(1);
    abro_cnt #(.W(CW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .i_load(w_load),
        .i_din (w_din),
        .i_en  (w_en),
        .i_up  (w_up),
        .i_term(w_term),
        .o_q   (w_q),
        .o_tc  (w_tc)
    );
    always_ff @(posedge clk) r_state <= !reset ? S_IDLE : w_next;
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_din  = '0;
        case (r_state)
            S_IDLE: if (w_accept) begin
                w_next = S_RST;
                w_load = 1'b1;
                w_din  = CW'(RST_LEN);
            end
            S_RST: if (w_tc) w_next = S_FIRST;
            S_FIRST: begin
                w_load = !O && r_mode == MODE_SIM || !O && r_gap != '0;
                w_din  = r_mode == MODE_SIM ? '0 : CW'(r_gap);
                w_next = O ? S_DONE : r_mode == MODE_SIM ? S_WAIT : r_gap == '0 ? S_SECOND : S_GAP;
            end
            S_GAP: w_next = O ? S_DONE : w_tc ? S_SECOND : S_GAP;
            S_SECOND: begin
                w_next = O ? S_DONE : S_WAIT;
                w_load = !O;
            end
            S_WAIT: if (O || w_tc) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end
    // Outputs are decoded from the next state so the registered pins line up with the state they belong to
    always_comb begin
        w_fa   = w_next == S_FIRST || (r_level && w_next inside {S_GAP, S_SECOND, S_WAIT});
        w_sa   = w_next == S_SECOND || (r_level && w_next == S_WAIT);
        w_a    = r_mode == MODE_BA ? w_sa : w_fa;
        w_b    = r_mode == MODE_AB ? w_sa : w_fa;
        w_rstn = w_next != S_RST;
        w_busy = w_next inside {S_RST, S_FIRST, S_GAP, S_SECOND, S_WAIT};
        w_done = w_next == S_DONE;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            {r_rstn, r_a, r_b, r_busy, r_done, r_pass, r_timeout, r_early} <= '0;
            r_lat   <= '0;
            r_mode  <= MODE_AB;
            r_level <= 1'b0;
            r_gap   <= '0;
        end else begin
            r_rstn <= w_rstn;
            r_a    <= w_a;
            r_b    <= w_b;
            r_busy <= w_busy;
            r_done <= w_done;
            if (r_state == S_IDLE && w_accept) begin
                r_mode    <= mode;
                r_level   <= level;
                r_gap     <= gap;
                r_pass    <= 1'b0;
                r_timeout <= 1'b0;
                r_early   <= 1'b0;
                r_lat     <= '0;
            end else if (r_state == S_WAIT && O) begin
                r_pass <= 1'b1;
                r_lat  <= LAT_W'(w_q);
            end else if (r_state == S_WAIT && w_tc)
                r_timeout <= 1'b1;
            else if (w_o_early)
                r_early <= 1'b1;
        end
    end
    assign dut_reset_n = r_rstn;
    assign A           = r_a;
    assign B           = r_b;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign timeout     = r_timeout;
    assign early       = r_early;
    assign o_latency   = r_lat;
endmodule

// File: tb/tb_abro_stim_driver.sv
// tb_abro_stim_driver: cycle-by-cycle check of the ABRO driver against a timeline model
module tb_abro_stim_driver;
    localparam int RST_LEN = 2;
    localparam int TIMEOUT = 16;
    logic clk = 0, reset = 0, start = 0, level = 0, O = 0;
    logic [1:0] mode = 0;
    logic [7:0] gap = 0;
    logic dut_reset_n, A, B, busy, done, pass, timeout, early;
    logic [4:0] o_latency;
    logic [12:0] obs;
    int errors = 0, checks = 0;
    int m_mode = 0, m_level = 0, m_gap = 0, m_to = 1000;
    abro_stim_driver #(.GAP_W(8), .TIMEOUT(TIMEOUT), .RST_LEN(RST_LEN), .LAT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .level(level), .gap(gap), .O(O),
        .dut_reset_n(dut_reset_n), .A(A), .B(B), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .early(early), .o_latency(o_latency)
    );
    always #5 clk = ~clk;
    assign obs = {dut_reset_n, A, B, busy, done, pass, timeout, early, o_latency};
    // Cycle c counts from the edge that accepts start; O is high from cycle m_to onward
    function automatic int wait_start();
        return m_mode == 2 ? RST_LEN + 2 : RST_LEN + m_gap + 3;
    endfunction
    function automatic int run_end();
        int f = RST_LEN + 1;
        int w0 = wait_start();
        if (m_to < w0) return (m_to > f ? m_to : f) + 1;
        return (m_to - w0 < TIMEOUT) ? m_to + 1 : w0 + TIMEOUT;
    endfunction
    function automatic logic [12:0] model(int c);
        int f = RST_LEN + 1;
        int w0 = wait_start();
        int dc = run_end();
        int lat;
        logic [2:0] res;
        logic fst, snd, a, b;
        res = m_to < w0 ? 3'b001 : (m_to - w0 < TIMEOUT) ? 3'b100 : 3'b010;
        lat = res == 3'b100 ? m_to - w0 : 0;
        if (c >= dc) return {1'b1, 2'b00, 1'b0, c == dc, res, 5'(lat)};
        fst = c == f || (m_level != 0 && c > f);
        snd = (m_mode != 2 && c == w0 - 1) || (m_level != 0 && c >= w0);
        a = m_mode == 1 ? snd : fst;
        b = m_mode == 0 ? snd : fst;
        return {c > RST_LEN, a, b, 1'b1, 1'b0, 3'b000, 5'd0};
    endfunction
    task automatic launch(int md, int lv, int gp, int to);
        m_mode = md; m_level = lv; m_gap = gp; m_to = to;
        mode = 2'(md); level = lv[0]; gap = 8'(gp); O = 0; start = 1;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
        start = 0;
    endtask
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== 13'h0) begin errors++; $display("FAIL reset_hold got %h want %h", obs, 13'h0); end
        end
        reset = 1;
        step();
        checks++;
        if (obs !== 13'h1000) begin errors++; $display("FAIL reset_release got %h want %h", obs, 13'h1000); end
    endtask
    task automatic test_ab_pulse();
        launch(0, 0, 3, RST_LEN + 8);
        for (int c = 1; c <= run_end() + 1; c++) begin
            step();
            checks++;
            if (obs !== model(c)) begin errors++; $display("FAIL ab_pulse c=%0d got %h want %h", c, obs, model(c)); end
            O = c >= m_to;
        end
        checks++;
        if ({pass, timeout, early, o_latency} !== 8'b100_00010) begin
            errors++; $display("FAIL ab_result got %b want %b", {pass, timeout, early, o_latency}, 8'b100_00010);
        end
    endtask
    task automatic test_sim_level();
        launch(2, 1, 0, RST_LEN + 2);
        for (int c = 1; c <= run_end() + 1; c++) begin
            step();
            checks++;
            if (obs !== model(c)) begin errors++; $display("FAIL sim_level c=%0d got %h want %h", c, obs, model(c)); end
            O = c >= m_to;
        end
        checks++;
        if ({pass, o_latency} !== 6'b1_00000) begin errors++; $display("FAIL sim_result got %b want %b", {pass, o_latency}, 6'b1_00000); end
    endtask
    task automatic test_ba_timeout();
        launch(1, 0, 0, 1000);
        for (int c = 1; c <= run_end() + 1; c++) begin
            step();
            checks++;
            if (obs !== model(c)) begin errors++; $display("FAIL ba_timeout c=%0d got %h want %h", c, obs, model(c)); end
            O = c >= m_to;
        end
        checks++;
        if ({pass, timeout} !== 2'b01) begin errors++; $display("FAIL timeout_result got %b want %b", {pass, timeout}, 2'b01); end
    endtask
    task automatic test_early();
        launch(0, 0, 5, RST_LEN + 3);
        for (int c = 1; c <= run_end() + 1; c++) begin
            step();
            checks++;
            if (obs !== model(c)) begin errors++; $display("FAIL early c=%0d got %h want %h", c, obs, model(c)); end
            O = c >= m_to;
        end
        checks++;
        if ({pass, early} !== 2'b01) begin errors++; $display("FAIL early_result got %b want %b", {pass, early}, 2'b01); end
    endtask
    task automatic test_random();
        int md, gp, lv, w0;
        for (int r = 0; r < 25; r++) begin
            md = $urandom_range(0, 2);
            gp = $urandom_range(0, 6);
            lv = $urandom_range(0, 1);
            w0 = md == 2 ? RST_LEN + 2 : RST_LEN + gp + 3;
            launch(md, lv, gp, $urandom_range(1, w0 + TIMEOUT + 2));
            for (int c = 1; c <= run_end() + 1; c++) begin
                step();
                checks++;
                if (obs !== model(c)) begin
                    errors++;
                    $display("FAIL random r=%0d mode=%0d lv=%0d gap=%0d to=%0d c=%0d got %h want %h",
                             r, md, lv, gp, m_to, c, obs, model(c));
                end
                O = c >= m_to;
            end
        end
    endtask
    task automatic test_bad_mode();
        mode = 2'b11; level = 1; gap = 8'd4; O = 0; start = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs !== model(1000)) begin errors++; $display("FAIL bad_mode i=%0d got %h want %h", i, obs, model(1000)); end
        end
    endtask
    task automatic test_reset_mid_run();
        launch(0, $urandom_range(0, 1), 5, 1000);
        for (int c = 1; c <= RST_LEN + 3; c++) begin
            step();
            checks++;
            if (obs !== model(c)) begin errors++; $display("FAIL abort_pre c=%0d got %h want %h", c, obs, model(c)); end
        end
        reset = 0;
        step();
        checks++;
        if (obs !== 13'h0) begin errors++; $display("FAIL abort_reset got %h want %h", obs, 13'h0); end
        reset = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs !== 13'h1000) begin errors++; $display("FAIL abort_idle i=%0d got %h want %h", i, obs, 13'h1000); end
        end
    endtask
    initial begin
        test_reset();
        test_ab_pulse();
        test_sim_level();
        test_ba_timeout();
        test_early();
        test_random();
        test_bad_mode();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
